// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared hold-level encoding, redirect constants and request payload for the hold controller.
package pipe_hold_ctrl_pkg;

    localparam int unsigned HOLD_W = 3;
    localparam int unsigned ADDR_W = 32;

    // Hold_Flag_Bus levels; a stage tagged with level L bubbles while the bus is >= L
    typedef enum logic [HOLD_W-1:0] {
        HOLD_NONE = 3'd0,
        HOLD_PC   = 3'd1,
        HOLD_IF   = 3'd2,
        HOLD_ID   = 3'd3
    } hold_lvl_e;

    localparam logic              JUMP_ENABLE  = 1'b1;
    localparam logic              JUMP_DISABLE = 1'b0;
    localparam logic [ADDR_W-1:0] ZERO_WORD    = '0;

    // One tagged hold request: active flag plus the level it asks for
    typedef struct packed {
        logic      req;
        hold_lvl_e level;
    } hold_req_t;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } ctrl_state_e;

    // Larger of two hold levels
    function automatic hold_lvl_e hold_max(input hold_lvl_e a, input hold_lvl_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hold_prio_merge.sv
// Combinational max-merge of four tagged hold requests into one Hold_Flag_Bus level.
module hold_prio_merge
    import pipe_hold_ctrl_pkg::*;
(
    input  hold_req_t req_a_i,
    input  hold_req_t req_b_i,
    input  hold_req_t req_c_i,
    input  hold_req_t req_d_i,
    output hold_lvl_e hold_o
);

    // Inactive requests contribute nothing; active ones compete on level
    always_comb begin
        hold_o = HOLD_NONE;
        if (req_a_i.req) hold_o = hold_max(hold_o, req_a_i.level);
        if (req_b_i.req) hold_o = hold_max(hold_o, req_b_i.level);
        if (req_c_i.req) hold_o = hold_max(hold_o, req_c_i.level);
        if (req_d_i.req) hold_o = hold_max(hold_o, req_d_i.level);
    end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: merges stall sources, drives PC redirect,
// holds a post-redirect flush window, counts stalled cycles and watches for stuck stalls.
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES  = 2,
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              hold_ex_i,
    input  logic              hold_rib_i,
    input  logic              hold_clint_i,
    input  logic              perf_clr_i,
    output logic [HOLD_W-1:0] hold_flag_o,
    output logic              jump_flag_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              stall_timeout_o
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int unsigned SR_W = $clog2(STALL_TIMEOUT + 1);

    ctrl_state_e      state_q, state_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [SR_W-1:0]  stall_run_q, stall_run_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    hold_req_t req_redir, req_clint, req_ex, req_rib;
    hold_lvl_e merged_lvl;
    logic      flush_active;
    logic      stalled;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // FSM next state: a redirect (re)opens the flush window, which then counts down
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            S_RUN: begin
                if (jump_flag_i && (FLUSH_CYCLES > 0)) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = FC_W'(FLUSH_CYCLES);
                end
            end
            S_FLUSH: begin
                if (jump_flag_i) begin
                    flush_cnt_d = FC_W'(FLUSH_CYCLES);
                end else if (flush_cnt_q == FC_W'(1)) begin
                    state_d     = S_RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            default: begin
                state_d     = S_RUN;
                flush_cnt_d = '0;
            end
        endcase
    end

    assign flush_active = (state_q == S_FLUSH);

    // Redirect and the flush window share one Hold_Id request
    assign req_redir = hold_req_t'{req: jump_flag_i | flush_active, level: HOLD_ID};
    assign req_clint = hold_req_t'{req: hold_clint_i,               level: HOLD_ID};
    assign req_ex    = hold_req_t'{req: hold_ex_i,                  level: HOLD_ID};
    assign req_rib   = hold_req_t'{req: hold_rib_i,                 level: HOLD_PC};

    hold_prio_merge u_merge (
        .req_a_i (req_redir),
        .req_b_i (req_clint),
        .req_c_i (req_ex),
        .req_d_i (req_rib),
        .hold_o  (merged_lvl)
    );

    // FSM outputs: zero-latency hold level and redirect, all quiet during reset
    always_comb begin
        hold_flag_o = HOLD_NONE;
        jump_flag_o = JUMP_DISABLE;
        jump_addr_o = ZERO_WORD;
        if (!rst) begin
            hold_flag_o = merged_lvl;
            if (jump_flag_i) begin
                jump_flag_o = JUMP_ENABLE;
                jump_addr_o = jump_addr_i;
            end
        end
    end

    assign stalled = (hold_flag_o != HOLD_NONE);

    // Watchdog run length register
    always_ff @(posedge clk) begin
        if (rst) stall_run_q <= '0;
        else     stall_run_q <= stall_run_d;
    end

    // Run length saturates at the timeout so the pulse fires once per stall episode
    always_comb begin
        stall_run_d = stall_run_q;
        if (!stalled) begin
            stall_run_d = '0;
        end else if (stall_run_q != SR_W'(STALL_TIMEOUT)) begin
            stall_run_d = stall_run_q + SR_W'(1);
        end
    end

    assign stall_timeout_o = stalled && (stall_run_q == SR_W'(STALL_TIMEOUT - 1));

    // Stall performance counter register
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    // Clear beats a same-cycle increment; the count wraps naturally
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr_i) begin
            stall_cnt_d = '0;
        end else if (stalled) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench for pipe_hold_ctrl with a cycle-level reference model and literal spot checks.
module tb_pipe_hold_ctrl;

    localparam int unsigned FLUSH_CYCLES  = 2;
    localparam int unsigned STALL_TIMEOUT = 8;
    localparam int unsigned CNT_W         = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_ex_i;
    logic        hold_rib_i;
    logic        hold_clint_i;
    logic        perf_clr_i;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic        stall_timeout_o;

    int vectors = 0;
    int errors  = 0;

    // Model state: cycle index, last cycle covered by the flush window,
    // length of the current stall run, and the counter value expected after the last edge
    int t           = 0;
    int flush_until = -1;
    int run_len     = 0;
    int exp_cnt     = 0;

    pipe_hold_ctrl #(
        .FLUSH_CYCLES  (FLUSH_CYCLES),
        .STALL_TIMEOUT (STALL_TIMEOUT),
        .CNT_W         (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .jump_flag_i     (jump_flag_i),
        .jump_addr_i     (jump_addr_i),
        .hold_ex_i       (hold_ex_i),
        .hold_rib_i      (hold_rib_i),
        .hold_clint_i    (hold_clint_i),
        .perf_clr_i      (perf_clr_i),
        .hold_flag_o     (hold_flag_o),
        .jump_flag_o     (jump_flag_o),
        .jump_addr_o     (jump_addr_o),
        .stall_cnt_o     (stall_cnt_o),
        .stall_timeout_o (stall_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, t, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic jf, input logic [31:0] ja,
                         input logic ex, input logic rib, input logic cl, input logic clr);
        rst = r; jump_flag_i = jf; jump_addr_i = ja;
        hold_ex_i = ex; hold_rib_i = rib; hold_clint_i = cl; perf_clr_i = clr;
    endtask

    // Sample mid-cycle, compare every output against the model, then advance the model
    task automatic settle();
        int  e_hold;
        bit  in_flush;
        bit  e_jf;
        bit  e_to;
        logic [31:0] e_addr;
        @(negedge clk);
        #1;
        in_flush = (t <= flush_until);
        e_hold = 0;
        if (!rst) begin
            if (hold_rib_i) e_hold = 1;
            if (jump_flag_i || hold_clint_i || hold_ex_i || in_flush) e_hold = 3;
        end
        e_jf   = !rst && jump_flag_i;
        e_addr = e_jf ? jump_addr_i : 32'h0;
        e_to   = (e_hold != 0) && (run_len + 1 == int'(STALL_TIMEOUT));
        check("m_hold",    64'(hold_flag_o),     64'(e_hold));
        check("m_jflag",   64'(jump_flag_o),     64'(e_jf));
        check("m_jaddr",   64'(jump_addr_o),     64'(e_addr));
        check("m_timeout", 64'(stall_timeout_o), 64'(e_to));
        check("m_cnt",     64'(stall_cnt_o),     64'(exp_cnt));
        if (rst) begin
            flush_until = -1;
            run_len     = 0;
            exp_cnt     = 0;
        end else begin
            if (jump_flag_i) flush_until = t + int'(FLUSH_CYCLES);
            run_len = (e_hold != 0) ? run_len + 1 : 0;
            if (perf_clr_i) exp_cnt = 0;
            else            exp_cnt = (exp_cnt + ((e_hold != 0) ? 1 : 0)) % (1 << CNT_W);
        end
        t++;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every request asserted
        drive(1, 1, 32'hDEAD_BEEF, 1, 1, 1, 0);
        settle();
        check("rst_hold",  64'(hold_flag_o), 64'd0);
        check("rst_jflag", 64'(jump_flag_o), 64'd0);
        check("rst_jaddr", 64'(jump_addr_o), 64'd0);
        next();
        settle();
        next();
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        settle();
        check("rel_cnt",  64'(stall_cnt_o), 64'd0);
        check("rel_hold", 64'(hold_flag_o), 64'd0);
        next();

        // Single redirect opens a two-cycle flush window
        drive(0, 1, 32'h100, 0, 0, 0, 0);
        settle();
        check("j_c0_hold",  64'(hold_flag_o), 64'd3);
        check("j_c0_jflag", 64'(jump_flag_o), 64'd1);
        check("j_c0_jaddr", 64'(jump_addr_o), 64'h100);
        next();
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        settle();
        check("j_c1_hold",  64'(hold_flag_o), 64'd3);
        check("j_c1_jflag", 64'(jump_flag_o), 64'd0);
        next();
        settle();
        check("j_c2_hold", 64'(hold_flag_o), 64'd3);
        next();
        settle();
        check("j_c3_hold", 64'(hold_flag_o), 64'd0);
        check("j_c3_cnt",  64'(stall_cnt_o), 64'd3);
        next();

        // Bus arbiter alone, then with EX, then both drop
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 0, 1, 0, 0);
            settle();
            check("rib_hold", 64'(hold_flag_o), 64'd1);
            next();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 32'h0, 1, 1, 0, 0);
            settle();
            check("rib_ex_hold", 64'(hold_flag_o), 64'd3);
            next();
        end
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        settle();
        check("drop_hold", 64'(hold_flag_o), 64'd0);
        check("drop_cnt",  64'(stall_cnt_o), 64'd8);
        next();

        // Watchdog: 16 stalled cycles give one pulse, a None cycle re-arms it
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 32'h0, 1, 0, 0, 0);
            settle();
            check("wd1_pulse", 64'(stall_timeout_o), 64'(i == 7));
            next();
        end
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        settle();
        check("wd_gap_cnt", 64'(stall_cnt_o), 64'd24);
        next();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 32'h0, 1, 0, 0, 0);
            settle();
            check("wd2_pulse", 64'(stall_timeout_o), 64'(i == 7));
            next();
        end
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        settle();
        check("wd_end_cnt", 64'(stall_cnt_o), 64'd32);
        next();

        // Back-to-back redirects: latest target wins, window restarts
        drive(0, 1, 32'h100, 0, 0, 0, 0);
        settle();
        check("bb_c0_jaddr", 64'(jump_addr_o), 64'h100);
        next();
        drive(0, 1, 32'h200, 0, 0, 0, 0);
        settle();
        check("bb_c1_jaddr", 64'(jump_addr_o), 64'h200);
        next();
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        settle();
        check("bb_c2_hold", 64'(hold_flag_o), 64'd3);
        next();
        settle();
        check("bb_c3_hold", 64'(hold_flag_o), 64'd3);
        next();
        settle();
        check("bb_c4_hold", 64'(hold_flag_o), 64'd0);
        next();

        // Reset in the middle of a flush window aborts it
        drive(0, 1, 32'h300, 0, 0, 0, 0);
        settle();
        next();
        drive(1, 1, 32'h400, 1, 0, 0, 0);
        settle();
        check("mid_rst_hold",  64'(hold_flag_o), 64'd0);
        check("mid_rst_jflag", 64'(jump_flag_o), 64'd0);
        next();
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        settle();
        check("post_rst_hold", 64'(hold_flag_o), 64'd0);
        check("post_rst_cnt",  64'(stall_cnt_o), 64'd0);
        next();

        // Counter wrap at 2^CNT_W
        for (int i = 0; i < 256; i++) begin
            drive(0, 0, 32'h0, 1, 0, 0, 0);
            settle();
            if (i == 255) check("wrap_full", 64'(stall_cnt_o), 64'hFF);
            next();
        end
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        settle();
        check("wrap_zero", 64'(stall_cnt_o), 64'd0);
        next();

        // Clear wins over a same-cycle increment
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 1, 0, 0, 0);
            settle();
            next();
        end
        drive(0, 0, 32'h0, 1, 0, 0, 1);
        settle();
        check("clr_before", 64'(stall_cnt_o), 64'd3);
        next();
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        settle();
        check("clr_after", 64'(stall_cnt_o), 64'd0);
        next();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
